// File: rtl/ra_bist_pkg.sv
// Shared types for the March C- BIST engine: FSM states, the per-element
// direction/polarity table and the default data backgrounds.
package ra_bist_pkg;

  typedef enum logic [3:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    M4,
    M5,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic desc;
    logic rd_pol;
    logic wr_pol;
  } elem_t;

  localparam logic [31:0] BG_A_DEF = 32'h0000_0000;
  localparam logic [31:0] BG_B_DEF = 32'h5555_5555;

  // Polarity 1 means the element reads/writes the inverted background.
  function automatic elem_t elem_info(input state_e st);
    elem_t e;
    e = '{desc: 1'b0, rd_pol: 1'b0, wr_pol: 1'b0};
    case (st)
      M1:      e = '{desc: 1'b0, rd_pol: 1'b0, wr_pol: 1'b1};
      M2:      e = '{desc: 1'b0, rd_pol: 1'b1, wr_pol: 1'b0};
      M3:      e = '{desc: 1'b1, rd_pol: 1'b0, wr_pol: 1'b1};
      M4:      e = '{desc: 1'b1, rd_pol: 1'b1, wr_pol: 1'b0};
      default: e = '{desc: 1'b0, rd_pol: 1'b0, wr_pol: 1'b0};
    endcase
    return e;
  endfunction

  function automatic state_e next_elem(input state_e st);
    state_e n;
    case (st)
      M0:      n = M1;
      M1:      n = M2;
      M2:      n = M3;
      M3:      n = M4;
      M4:      n = M5;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ra_bist_chk.sv
// Read-data checker: carries expected data/address/valid for RD_LAT cycles
// alongside each read and latches the first miscompare.
module ra_bist_chk
  import ra_bist_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          vld_0_i,
  input  logic          vld_1_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] exp_i,
  input  logic [DW-1:0] rd_dat_0_i,
  input  logic [DW-1:0] rd_dat_1_i,
  output logic          fail_o,
  output logic [AW-1:0] fail_adr_o,
  output logic          fail_port_o
);

  logic          vld_0_q [RD_LAT];
  logic          vld_1_q [RD_LAT];
  logic [AW-1:0] adr_q   [RD_LAT];
  logic [DW-1:0] exp_q   [RD_LAT];
  logic          fail_q;
  logic [AW-1:0] fail_adr_q;
  logic          fail_port_q;
  logic          miss_0;
  logic          miss_1;

  assign miss_0 = vld_0_q[RD_LAT-1] && (rd_dat_0_i != exp_q[RD_LAT-1]);
  assign miss_1 = vld_1_q[RD_LAT-1] && (rd_dat_1_i != exp_q[RD_LAT-1]);

  // A new run flushes the pipeline as well as the sticky result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_0_q[i] <= 1'b0;
        vld_1_q[i] <= 1'b0;
        adr_q[i]   <= '0;
        exp_q[i]   <= '0;
      end
      fail_q      <= 1'b0;
      fail_adr_q  <= '0;
      fail_port_q <= 1'b0;
    end else if (clr_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_0_q[i] <= 1'b0;
        vld_1_q[i] <= 1'b0;
        adr_q[i]   <= '0;
        exp_q[i]   <= '0;
      end
      fail_q      <= 1'b0;
      fail_adr_q  <= '0;
      fail_port_q <= 1'b0;
    end else begin
      vld_0_q[0] <= vld_0_i;
      vld_1_q[0] <= vld_1_i;
      adr_q[0]   <= adr_i;
      exp_q[0]   <= exp_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_0_q[i] <= vld_0_q[i-1];
        vld_1_q[i] <= vld_1_q[i-1];
        adr_q[i]   <= adr_q[i-1];
        exp_q[i]   <= exp_q[i-1];
      end
      // Port 0 wins a simultaneous double miscompare.
      if (!fail_q && (miss_0 || miss_1)) begin
        fail_q      <= 1'b1;
        fail_adr_q  <= adr_q[RD_LAT-1];
        fail_port_q <= !miss_0;
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_adr_o  = fail_adr_q;
  assign fail_port_o = fail_port_q;

endmodule

// File: rtl/ra_2r1w_bist_march.sv
// March C- BIST engine for the 2r1w array: FSM, address sequencing and
// registered drive of the read/write ports, two passes with different backgrounds.
module ra_2r1w_bist_march
  import ra_bist_pkg::*;
#(
  parameter int            DW     = 32,
  parameter int            AW     = 5,
  parameter int            RD_LAT = 1,
  parameter logic [DW-1:0] BG_A   = DW'(BG_A_DEF),
  parameter logic [DW-1:0] BG_B   = DW'(BG_B_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bist_start,
  output logic          bist_busy,
  output logic          bist_done,
  output logic          bist_fail,
  output logic [AW-1:0] fail_adr,
  output logic          fail_port,
  output logic          rd_enb_0,
  output logic [AW-1:0] rd_adr_0,
  input  logic [DW-1:0] rd_dat_0,
  output logic          rd_enb_1,
  output logic [AW-1:0] rd_adr_1,
  input  logic [DW-1:0] rd_dat_1,
  output logic          wr_enb_0,
  output logic [AW-1:0] wr_adr_0,
  output logic [DW-1:0] wr_dat_0
);

  localparam int            DEPTH      = 2 ** AW;
  localparam logic [AW-1:0] ADR_MAX    = AW'(DEPTH - 1);
  localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT);

  state_e        state_q, state_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          phase_q, phase_d;
  logic [1:0]    drain_q, drain_d;
  logic          rd_enb_0_q, rd_enb_0_d, rd_enb_1_q, rd_enb_1_d, wr_enb_0_q, wr_enb_0_d;
  logic [AW-1:0] rd_adr_0_q, rd_adr_0_d, rd_adr_1_q, rd_adr_1_d, wr_adr_0_q, wr_adr_0_d;
  logic [DW-1:0] wr_dat_0_q, wr_dat_0_d, exp_q, exp_d;
  logic [DW-1:0] bg;
  logic          clr;
  logic          step;
  elem_t         el;
  elem_t         nxt_el;
  state_e        nxt;

  // Two-op elements use phase 0 for the read and phase 1 for the write;
  // the address only advances once an address's last op has been issued.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    adr_d      = adr_q;
    phase_d    = phase_q;
    drain_d    = drain_q;
    rd_enb_0_d = 1'b0;
    rd_enb_1_d = 1'b0;
    wr_enb_0_d = 1'b0;
    rd_adr_0_d = '0;
    rd_adr_1_d = '0;
    wr_adr_0_d = '0;
    wr_dat_0_d = '0;
    exp_d      = '0;
    clr        = 1'b0;
    step       = 1'b0;
    bg         = pass_q ? BG_B : BG_A;
    el         = elem_info(state_q);
    nxt        = next_elem(state_q);
    nxt_el     = elem_info(nxt);
    case (state_q)
      IDLE, DONE: begin
        if (bist_start) begin
          state_d = M0;
          pass_d  = 1'b0;
          adr_d   = '0;
          phase_d = 1'b0;
          clr     = 1'b1;
        end
      end
      M0: begin
        wr_enb_0_d = 1'b1;
        wr_adr_0_d = adr_q;
        wr_dat_0_d = bg;
        step       = 1'b1;
      end
      M5: begin
        rd_enb_0_d = 1'b1;
        rd_enb_1_d = 1'b1;
        rd_adr_0_d = adr_q;
        rd_adr_1_d = adr_q;
        exp_d      = bg;
        step       = 1'b1;
      end
      M1, M2, M3, M4: begin
        if (!phase_q) begin
          rd_enb_0_d = 1'b1;
          rd_adr_0_d = adr_q;
          exp_d      = el.rd_pol ? ~bg : bg;
          phase_d    = 1'b1;
        end else begin
          wr_enb_0_d = 1'b1;
          wr_adr_0_d = adr_q;
          wr_dat_0_d = el.wr_pol ? ~bg : bg;
          phase_d    = 1'b0;
          step       = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else drain_d = drain_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
    if (step) begin
      if (adr_q == (el.desc ? '0 : ADR_MAX)) begin
        if (state_q == M5) begin
          adr_d = '0;
          if (!pass_q) begin
            state_d = M0;
            pass_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = 2'd0;
          end
        end else begin
          state_d = nxt;
          adr_d   = nxt_el.desc ? ADR_MAX : '0;
        end
      end else begin
        adr_d = el.desc ? adr_q - 1'b1 : adr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pass_q     <= 1'b0;
      adr_q      <= '0;
      phase_q    <= 1'b0;
      drain_q    <= 2'd0;
      rd_enb_0_q <= 1'b0;
      rd_enb_1_q <= 1'b0;
      wr_enb_0_q <= 1'b0;
      rd_adr_0_q <= '0;
      rd_adr_1_q <= '0;
      wr_adr_0_q <= '0;
      wr_dat_0_q <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      adr_q      <= adr_d;
      phase_q    <= phase_d;
      drain_q    <= drain_d;
      rd_enb_0_q <= rd_enb_0_d;
      rd_enb_1_q <= rd_enb_1_d;
      wr_enb_0_q <= wr_enb_0_d;
      rd_adr_0_q <= rd_adr_0_d;
      rd_adr_1_q <= rd_adr_1_d;
      wr_adr_0_q <= wr_adr_0_d;
      wr_dat_0_q <= wr_dat_0_d;
      exp_q      <= exp_d;
    end
  end

  ra_bist_chk #(
    .DW    (DW),
    .AW    (AW),
    .RD_LAT(RD_LAT)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (clr),
    .vld_0_i    (rd_enb_0_q),
    .vld_1_i    (rd_enb_1_q),
    .adr_i      (rd_adr_0_q),
    .exp_i      (exp_q),
    .rd_dat_0_i (rd_dat_0),
    .rd_dat_1_i (rd_dat_1),
    .fail_o     (bist_fail),
    .fail_adr_o (fail_adr),
    .fail_port_o(fail_port)
  );

  assign bist_busy = (state_q != IDLE) && (state_q != DONE);
  assign bist_done = (state_q == DONE);
  assign rd_enb_0  = rd_enb_0_q;
  assign rd_adr_0  = rd_adr_0_q;
  assign rd_enb_1  = rd_enb_1_q;
  assign rd_adr_1  = rd_adr_1_q;
  assign wr_enb_0  = wr_enb_0_q;
  assign wr_adr_0  = wr_adr_0_q;
  assign wr_dat_0  = wr_dat_0_q;

endmodule

// File: tb/tb_ra_2r1w_bist_march.sv
// Directed bench for the March C- engine against a behavioural 2r1w array
// (RD_LAT=1) with switchable stuck-bit and port-1 corruption faults.
module tb_ra_2r1w_bist_march;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bist_start = 1'b0;
  logic        bist_busy, bist_done, bist_fail, fail_port;
  logic [4:0]  fail_adr;
  logic        rd_enb_0, rd_enb_1, wr_enb_0;
  logic [4:0]  rd_adr_0, rd_adr_1, wr_adr_0;
  logic [31:0] rd_dat_0, rd_dat_1, wr_dat_0;

  logic [31:0] mem [32];
  logic        faultStuck = 1'b0;
  logic        faultPort1 = 1'b0;

  int checkCount = 0;
  int errorCount = 0;
  int nWr, nRd, doneEdge, lastBusy, failEdge;
  int m3Exp, m3Err, m3Wr, m3DatCnt, m3DatErr;
  logic s0Busy, s0Done, s0Fail, s0Port, midBusy;
  logic [4:0] s0Adr;
  logic [58:0] afterReset;

  ra_2r1w_bist_march dut (
    .clk       (clk),
    .reset     (reset),
    .bist_start(bist_start),
    .bist_busy (bist_busy),
    .bist_done (bist_done),
    .bist_fail (bist_fail),
    .fail_adr  (fail_adr),
    .fail_port (fail_port),
    .rd_enb_0  (rd_enb_0),
    .rd_adr_0  (rd_adr_0),
    .rd_dat_0  (rd_dat_0),
    .rd_enb_1  (rd_enb_1),
    .rd_adr_1  (rd_adr_1),
    .rd_dat_1  (rd_dat_1),
    .wr_enb_0  (wr_enb_0),
    .wr_adr_0  (wr_adr_0),
    .wr_dat_0  (wr_dat_0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] readModel(input logic [4:0] a, input logic port);
    logic [31:0] d;
    d = mem[a];
    if (faultStuck && a == 5'd7) d = d | 32'h0000_0008;
    if (faultPort1 && port && a == 5'd31) d = d ^ 32'h0000_0001;
    return d;
  endfunction

  // Array model: one-cycle read latency, registered read data.
  always @(posedge clk) begin
    if (wr_enb_0) mem[wr_adr_0] <= wr_dat_0;
    if (rd_enb_0) rd_dat_0 <= readModel(rd_adr_0, 1'b0);
    if (rd_enb_1) rd_dat_1 <= readModel(rd_adr_1, 1'b1);
  end

  function automatic logic [58:0] outs();
    return {bist_busy, bist_done, bist_fail, fail_adr, fail_port, rd_enb_0, rd_adr_0,
            rd_enb_1, rd_adr_1, wr_enb_0, wr_adr_0, wr_dat_0};
  endfunction

  // Start a run at edge 0 and observe edges until done (or abortEdge, where reset is pulled).
  task automatic run_bist(input int extraStart, input int abortEdge);
    int edgeN;
    nWr = 0; nRd = 0; doneEdge = -1; lastBusy = -1; failEdge = -1;
    m3Exp = 31; m3Err = 0; m3Wr = 0; m3DatCnt = 0; m3DatErr = 0; midBusy = 1'b0;
    @(negedge clk);
    bist_start = 1'b1;
    @(posedge clk);
    #1;
    bist_start = 1'b0;
    s0Busy = bist_busy; s0Done = bist_done; s0Fail = bist_fail; s0Adr = fail_adr; s0Port = fail_port;
    if (bist_busy) lastBusy = 0;
    edgeN = 0;
    while (edgeN < 1000 && doneEdge < 0) begin
      bist_start = (extraStart > 0 && edgeN == extraStart - 1);
      @(posedge clk);
      #1;
      edgeN++;
      if (wr_enb_0) nWr++;
      if (rd_enb_0) nRd++;
      if (rd_enb_1) nRd++;
      if (bist_busy) lastBusy = edgeN;
      if (bist_fail && failEdge < 0) failEdge = edgeN;
      if (bist_done && doneEdge < 0) doneEdge = edgeN;
      if (edgeN >= 161 && edgeN <= 224 && wr_enb_0) begin
        m3Wr++;
        if (wr_adr_0 !== 5'(m3Exp)) m3Err++;
        m3Exp--;
      end
      if (edgeN >= 481 && edgeN <= 544 && wr_enb_0) begin
        m3DatCnt++;
        if (wr_dat_0 !== 32'hAAAA_AAAA) m3DatErr++;
      end
      if (abortEdge > 0 && edgeN == abortEdge) begin
        midBusy = bist_busy;
        #2 reset = 1'b0;
        #1 afterReset = outs();
        return;
      end
    end
    bist_start = 1'b0;
    if (doneEdge < 0) begin
      checkCount++; errorCount++;
      $display("[TB] FAIL run_timeout: done not seen after %0d edges, required by edge 642", edgeN);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (outs() !== 59'd0) begin
      errorCount++; $display("[TB] FAIL reset_outs: got %h required 0", outs());
    end
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if ({bist_busy, bist_done, rd_enb_0, rd_enb_1, wr_enb_0} !== 5'b0) begin
      errorCount++; $display("[TB] FAIL idle_after_reset: busy=%b done=%b required both 0", bist_busy, bist_done);
    end
  endtask

  task automatic test_clean_run();
    run_bist(0, 0);
    checkCount++;
    if (s0Busy !== 1'b1) begin errorCount++; $display("[TB] FAIL busy_edge0: got %b required 1", s0Busy); end
    checkCount++;
    if (lastBusy !== 641) begin errorCount++; $display("[TB] FAIL busy_last_edge: got %0d required 641", lastBusy); end
    checkCount++;
    if (doneEdge !== 642) begin errorCount++; $display("[TB] FAIL done_edge: got %0d required 642", doneEdge); end
    checkCount++;
    if (bist_fail !== 1'b0) begin errorCount++; $display("[TB] FAIL clean_fail: got %b required 0", bist_fail); end
    checkCount++;
    if (nWr !== 320) begin errorCount++; $display("[TB] FAIL write_count: got %0d required 320", nWr); end
    checkCount++;
    if (nRd !== 384) begin errorCount++; $display("[TB] FAIL read_count: got %0d required 384", nRd); end
    checkCount++;
    if (m3Wr !== 32 || m3Err !== 0) begin
      errorCount++; $display("[TB] FAIL m3_descending: writes=%0d bad=%0d required 32 and 0", m3Wr, m3Err);
    end
    checkCount++;
    if (m3DatCnt !== 32 || m3DatErr !== 0) begin
      errorCount++; $display("[TB] FAIL m3_pass1_data: writes=%0d bad=%0d required 32 and 0", m3DatCnt, m3DatErr);
    end
  endtask

  task automatic test_stuck_fault();
    faultStuck = 1'b1;
    run_bist(0, 0);
    faultStuck = 1'b0;
    checkCount++;
    if (bist_done !== 1'b1 || bist_fail !== 1'b1) begin
      errorCount++; $display("[TB] FAIL stuck_flags: done=%b fail=%b required 1 1", bist_done, bist_fail);
    end
    checkCount++;
    if (fail_adr !== 5'd7 || fail_port !== 1'b0) begin
      errorCount++; $display("[TB] FAIL stuck_where: adr=%0d port=%b required 7 0", fail_adr, fail_port);
    end
    checkCount++;
    if (failEdge !== 49) begin errorCount++; $display("[TB] FAIL stuck_edge: got %0d required 49", failEdge); end
  endtask

  task automatic test_restart_clears();
    run_bist(0, 0);
    checkCount++;
    if ({s0Busy, s0Done, s0Fail, s0Adr, s0Port} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL restart_clear: busy=%b done=%b fail=%b adr=%0d port=%b required 1 0 0 0 0",
               s0Busy, s0Done, s0Fail, s0Adr, s0Port);
    end
    checkCount++;
    if (bist_fail !== 1'b0 || doneEdge !== 642) begin
      errorCount++; $display("[TB] FAIL restart_run: fail=%b done_edge=%0d required 0 642", bist_fail, doneEdge);
    end
  endtask

  task automatic test_port1_fault();
    faultPort1 = 1'b1;
    run_bist(0, 0);
    faultPort1 = 1'b0;
    checkCount++;
    if (bist_fail !== 1'b1 || fail_adr !== 5'd31 || fail_port !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL port1_where: fail=%b adr=%0d port=%b required 1 31 1", bist_fail, fail_adr, fail_port);
    end
    checkCount++;
    if (failEdge !== 322) begin errorCount++; $display("[TB] FAIL port1_edge: got %0d required 322", failEdge); end
  endtask

  task automatic test_start_while_busy();
    run_bist(100, 0);
    checkCount++;
    if (s0Fail !== 1'b0 || s0Adr !== 5'd0 || s0Done !== 1'b0) begin
      errorCount++; $display("[TB] FAIL done_restart_clear: fail=%b adr=%0d done=%b required 0 0 0", s0Fail, s0Adr, s0Done);
    end
    checkCount++;
    if (doneEdge !== 642 || nWr !== 320) begin
      errorCount++; $display("[TB] FAIL busy_start_ignored: done_edge=%0d writes=%0d required 642 320", doneEdge, nWr);
    end
    checkCount++;
    if (bist_fail !== 1'b0) begin errorCount++; $display("[TB] FAIL busy_start_fail: got %b required 0", bist_fail); end
  endtask

  task automatic test_reset_mid_run();
    run_bist(0, 130);
    checkCount++;
    if (midBusy !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_busy: got %b required 1", midBusy); end
    checkCount++;
    if (afterReset !== 59'd0) begin errorCount++; $display("[TB] FAIL async_reset_outs: got %h required 0", afterReset); end
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (outs() !== 59'd0) begin errorCount++; $display("[TB] FAIL post_reset_idle: got %h required 0", outs()); end
    run_bist(0, 0);
    checkCount++;
    if (bist_fail !== 1'b0 || bist_done !== 1'b1 || doneEdge !== 642) begin
      errorCount++;
      $display("[TB] FAIL rerun_after_reset: fail=%b done=%b done_edge=%0d required 0 1 642", bist_fail, bist_done, doneEdge);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_stuck_fault();
    test_restart_clears();
    test_port1_fault();
    test_start_while_busy();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ra_2r1w_bist_march.md
Name: ra_2r1w_bist_march

Overview:
- March C- built-in self-test engine. Sits directly upstream of ra_2r1w_32x32_sdr and drives its read-port-0, read-port-1 and write-port-0 pins.
- Compares returned rd_dat_0 and rd_dat_1 against expected data.
- Reports pass/fail and the first failing address and port.
- The mission-mode/BIST port mux is a separate integration-level block and is not part of this block.

Parameters:
- DW, 32, data width of the array word.
- AW, 5, address width; DEPTH = 2**AW is derived as a localparam.
- RD_LAT, 1, cycles from rd_enb/rd_adr sampled to rd_dat valid; range 1..3.
- BG_A, 32'h0000_0000, data background for pass 0.
- BG_B, 32'h5555_5555, data background for pass 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- bist_start  in  1  start request; sampled on a rising edge.
- bist_busy  out  1  test in progress.
- bist_done  out  1  sticky completion flag.
- bist_fail  out  1  sticky fail flag.
- fail_adr  out  AW  address of the first miscompare.
- fail_port  out  1  read port of the first miscompare: 0 or 1.
- rd_enb_0  out  1  array read port 0 enable.
- rd_adr_0  out  AW  array read port 0 address.
- rd_dat_0  in  DW  array read port 0 data.
- rd_enb_1  out  1  array read port 1 enable.
- rd_adr_1  out  AW  array read port 1 address.
- rd_dat_1  in  DW  array read port 1 data.
- wr_enb_0  out  1  array write enable.
- wr_adr_0  out  AW  array write address.
- wr_dat_0  out  DW  array write data.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE and every output is 0, including the sticky flags, fail_adr and fail_port. The compare pipeline is flushed. Reset asserted mid-test aborts immediately; no partial result is kept.
- All array-facing outputs are registered. At most one enable is high per cycle, except in M5, where rd_enb_0 and rd_enb_1 are both high.
- Start:
  - bist_start=1 in IDLE or DONE clears bist_done, bist_fail, fail_adr and fail_port, and sets bist_busy on the same edge.
  - bist_start while busy is ignored.
- Write data: with the current background BG, "w0" writes BG and "w1" writes ~BG.
- States, in order: IDLE, then M0..M5 for pass 0, then M0..M5 for pass 1 (pass bit selects BG_A or BG_B), then DRAIN, then DONE.
  - M0: ascending address 0..DEPTH-1, w0, one write per cycle.
  - M1: ascending; per address, cycle A = r0, cycle B = w1.
  - M2: ascending; r1 then w0.
  - M3: descending address DEPTH-1..0; r0 then w1.
  - M4: descending; r1 then w0.
  - M5: ascending; ports 0 and 1 both read the same address in one cycle; both expect BG.
  - Read and write never target the array in the same cycle.
- Sequencing:
  - Address counter wraps at the element boundary and the next element starts on the following cycle, with no bubble.
  - Op count per pass = DEPTH + 4*2*DEPTH + DEPTH = 320 for DEPTH=32; 640 total.
  - The first op is issued at edge 1 (start sampled at edge 0); the last op is issued at edge 640.
- Compare pipeline:
  - Expected data, address, port and valid are delayed RD_LAT stages alongside each read.
  - Compare happens when the delayed valid is high; a miscompare is any bit mismatch.
  - The first miscompare sets bist_fail and captures fail_adr and fail_port. Later miscompares are ignored.
  - If both ports miscompare in the same cycle, fail_port=0.
  - The test always runs to completion; a failure does not stop it.
- Completion:
  - DRAIN lasts RD_LAT cycles.
  - At edge 641+RD_LAT: bist_busy falls, bist_done rises, state goes to DONE.
  - bist_done holds until the next start or reset.

Decomposition:
- Package ra_bist_pkg holds:
  - the state enum (IDLE, M0..M5, DRAIN, DONE);
  - the per-element direction and expected/written polarity table;
  - the BG_A and BG_B default constants.
- Sub-module ra_bist_chk: RD_LAT-deep expected-data pipeline plus comparator and first-fail capture.
- The top level holds the FSM, the address counter and the port drive.

Test Plan:
- Fault-free behavioural 2r1w array model (RD_LAT=1), single start pulse:
  - busy high from edge 0 through edge 641;
  - done=1 at edge 642, fail=0;
  - exactly 320 writes and 384 read enables counted (256 from M1-M4 plus 128 from M5).
- Model bit 3 of address 7 stuck-at-1: done=1, fail=1, fail_adr=5'd7, fail_port=0, first capture during pass-0 M1.
- Model corrupts only port-1 read data at address 31: fail=1, fail_adr=5'd31, fail_port=1 (detected in pass-0 M5).
- Monitor wr_adr_0 during M3: strictly descending 31..0. wr_dat_0 in pass-1 M3 = 32'hAAAA_AAAA.
- reset driven 0 mid-M2:
  - all outputs 0 asynchronously, before the next edge;
  - after release, a restart gives a clean pass with fail=0.
- bist_start pulsed while busy: ignored, and total run length is unchanged. bist_start pulsed in DONE after a failing run: done, fail and fail_adr clear on the same edge and a new run begins.
